// File: rtl/sha256_msg_padder_if.sv
// Byte-in / word-out stream bundle between a message source, the SHA-256
// padder and the compression core.
interface sha256_msg_padder_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        in_empty;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_blk_last;
  logic        out_msg_last;
  logic        busy;

  modport master (
    output in_byte, in_valid, in_last, in_empty, out_ready,
    input  in_ready, out_word, out_valid, out_blk_last, out_msg_last, busy
  );

  modport slave (
    input  in_byte, in_valid, in_last, in_empty, out_ready,
    output in_ready, out_word, out_valid, out_blk_last, out_msg_last, busy
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into big-endian 32-bit words
// and appends the 0x80 marker, zero fill and 64-bit bit length.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input logic              clk,
  input logic              reset,
  sha256_msg_padder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_DATA  = 3'd0,
    ST_PAD80 = 3'd1,
    ST_ZERO  = 3'd2,
    ST_LEN   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [5:0]        pos_r;
  logic [LEN_W-1:0]  bitcnt_r;
  logic [23:0]       asm_r;
  logic [2:0]        len_idx_r;
  logic [31:0]       out_word_r;
  logic              out_valid_r;
  logic              blk_last_r;
  logic              msg_last_r;
  logic              busy_r;

  logic              stall_s;
  logic              out_fire_s;
  logic              in_ready_s;
  logic              xfer_s;
  logic              byte_en_s;
  logic [7:0]        byte_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_DATA;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; padding states advance only when their byte is inserted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_DATA: begin
        if (xfer_s && bus.in_last) state_s = ST_PAD80;
        else                       state_s = ST_DATA;
      end
      ST_PAD80: begin
        if (!byte_en_s)            state_s = ST_PAD80;
        else if (pos_r == 6'd55)   state_s = ST_LEN;
        else                       state_s = ST_ZERO;
      end
      ST_ZERO: begin
        if (byte_en_s && pos_r == 6'd55) state_s = ST_LEN;
        else                             state_s = ST_ZERO;
      end
      ST_LEN: begin
        if (byte_en_s && len_idx_r == 3'd7) state_s = ST_FLUSH;
        else                                state_s = ST_LEN;
      end
      ST_FLUSH: begin
        if (out_fire_s) state_s = ST_DATA;
        else            state_s = ST_FLUSH;
      end
      default: state_s = ST_DATA;
    endcase
  end

  // Output decode: which byte (if any) enters the assembler this cycle.
  always_comb begin
    stall_s    = out_valid_r && !bus.out_ready;
    out_fire_s = out_valid_r && bus.out_ready;
    in_ready_s = 1'b0;
    xfer_s     = 1'b0;
    byte_en_s  = 1'b0;
    byte_s     = 8'h00;
    case (state_r)
      ST_DATA: begin
        in_ready_s = !reset && !stall_s;
        // in_empty only means something together with in_last
        xfer_s     = bus.in_valid && in_ready_s && (bus.in_last || !bus.in_empty);
        byte_en_s  = xfer_s && !bus.in_empty;
        byte_s     = bus.in_byte;
      end
      ST_PAD80: begin
        byte_en_s = !stall_s;
        byte_s    = 8'h80;
      end
      ST_ZERO: begin
        byte_en_s = !stall_s;
        byte_s    = 8'h00;
      end
      ST_LEN: begin
        byte_en_s = !stall_s;
        byte_s    = bitcnt_r[LEN_W-1 -: 8];
      end
      ST_FLUSH: begin
        byte_en_s = 1'b0;
        byte_s    = 8'h00;
      end
      default: begin
        byte_en_s = 1'b0;
        byte_s    = 8'h00;
      end
    endcase
  end

  // Word assembly, output register, bit counter and busy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_r       <= 6'd0;
      bitcnt_r    <= '0;
      asm_r       <= 24'd0;
      len_idx_r   <= 3'd0;
      out_word_r  <= 32'd0;
      out_valid_r <= 1'b0;
      blk_last_r  <= 1'b0;
      msg_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (byte_en_s) begin
        pos_r <= pos_r + 6'd1;
        if (pos_r[1:0] == 2'd3) begin
          out_word_r  <= {asm_r, byte_s};
          out_valid_r <= 1'b1;
          blk_last_r  <= (pos_r == 6'd63);
          msg_last_r  <= (state_r == ST_LEN) && (len_idx_r == 3'd7);
        end else begin
          asm_r <= {asm_r[15:0], byte_s};
          if (out_fire_s) out_valid_r <= 1'b0;
        end
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
      end

      // The length field is shifted out MSB first, consuming the counter.
      if (byte_en_s && state_r == ST_DATA) begin
        bitcnt_r <= bitcnt_r + LEN_W'(8);
      end else if (byte_en_s && state_r == ST_LEN) begin
        bitcnt_r  <= {bitcnt_r[LEN_W-9:0], 8'h00};
        len_idx_r <= len_idx_r + 3'd1;
      end else if (state_r == ST_FLUSH && out_fire_s) begin
        bitcnt_r  <= '0;
        len_idx_r <= 3'd0;
        pos_r     <= 6'd0;
      end

      if (xfer_s) begin
        busy_r <= 1'b1;
      end else if (state_r == ST_FLUSH && out_fire_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_word     = out_word_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_blk_last = blk_last_r;
  assign bus.out_msg_last = msg_last_r;
  assign bus.busy         = busy_r;

endmodule
